// File: rtl/sram_line_arbiter.sv
// Two-requester round-robin arbiter in front of the SRAM line-wrapper slave port.
// Optional watchdog with per-requester error pulses: define SRAM_LINE_ARB_TIMEOUT_EN.
module sram_line_arbiter #(
  parameter int WR_GUARD = 18,
  parameter int CNT_W    = 5
`ifdef SRAM_LINE_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 1023
`endif
) (
  input  logic         clkCPU,
  input  logic         rst,
  input  logic [31:0]  m0_addr,
  input  logic [767:0] m0_din,
  input  logic [95:0]  m0_dm,
  input  logic         m0_stb,
  input  logic         m0_we,
  output logic         m0_ack,
  output logic [767:0] m0_dout,
  input  logic [31:0]  m1_addr,
  input  logic [767:0] m1_din,
  input  logic [95:0]  m1_dm,
  input  logic         m1_stb,
  input  logic         m1_we,
  output logic         m1_ack,
  output logic [767:0] m1_dout,
  output logic [31:0]  ws_addr,
  output logic [767:0] ws_din,
  output logic [95:0]  ws_dm,
  output logic         ws_stb,
  output logic         ws_we,
  input  logic         ws_ack,
  input  logic [767:0] ws_dout,
  input  logic         sram_stb_mon,
  input  logic         sram_nak_mon
`ifdef SRAM_LINE_ARB_TIMEOUT_EN
  ,
  output logic         m0_err,
  output logic         m1_err
`endif
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, RESP, GUARD, DRAIN} state_t;

  state_t         r_state, w_next;
  logic           r_grant;      // 0 = m0, 1 = m1
  logic           r_rr_last;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]    r_ws_addr;
  logic [767:0]   r_ws_din;
  logic [95:0]    r_ws_dm;
  logic           r_ws_we;
  logic [767:0]   r_m0_dout, r_m1_dout;
  logic           w_any_req, w_win_m1, w_timeout;

`ifdef SRAM_LINE_ARB_TIMEOUT_EN
  logic [9:0]     r_wd;
  logic           r_err;
  assign w_timeout = (r_wd == 10'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  assign w_any_req = m0_stb | m1_stb;
  // On a tie the requester that did not win last time is served.
  assign w_win_m1  = m1_stb & (~m0_stb | ~r_rr_last);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_any_req) w_next = ISSUE;
      ISSUE:    w_next = WAIT_ACK;
      WAIT_ACK: if (ws_ack || w_timeout) w_next = RESP;
      RESP:     w_next = r_ws_we ? GUARD : IDLE;
      GUARD:    if (r_cnt == '0) w_next = DRAIN;
      DRAIN:    if (!sram_stb_mon && !sram_nak_mon) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clkCPU or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clkCPU or negedge rst) begin
    if (!rst) begin
      r_grant   <= 1'b0;
      r_rr_last <= 1'b1;
      r_cnt     <= '0;
      r_ws_addr <= '0;
      r_ws_din  <= '0;
      r_ws_dm   <= '0;
      r_ws_we   <= 1'b0;
      r_m0_dout <= '0;
      r_m1_dout <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any_req) begin
          r_grant   <= w_win_m1;
          r_rr_last <= w_win_m1;
          r_ws_addr <= w_win_m1 ? m1_addr : m0_addr;
          r_ws_din  <= w_win_m1 ? m1_din  : m0_din;
          r_ws_dm   <= w_win_m1 ? m1_dm   : m0_dm;
          r_ws_we   <= w_win_m1 ? m1_we   : m0_we;
        end
        WAIT_ACK: if (ws_ack) begin
          // Writes leave the requester's read line untouched.
          if (!r_ws_we) begin
            if (r_grant) r_m1_dout <= ws_dout;
            else         r_m0_dout <= ws_dout;
          end
        end
        RESP:  if (r_ws_we) r_cnt <= CNT_W'(WR_GUARD);
        GUARD: if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef SRAM_LINE_ARB_TIMEOUT_EN
  // A real ack wins over a simultaneous watchdog expiry.
  always_ff @(posedge clkCPU or negedge rst) begin
    if (!rst) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        ISSUE: begin
          r_wd  <= '0;
          r_err <= 1'b0;
        end
        WAIT_ACK: begin
          r_wd <= r_wd + 1'b1;
          if (!ws_ack && w_timeout) r_err <= 1'b1;
        end
        RESP:    r_err <= r_err;
        default: r_err <= 1'b0;
      endcase
    end
  end

  assign m0_err = (r_state == RESP) & ~r_grant & r_err;
  assign m1_err = (r_state == RESP) &  r_grant & r_err;
`endif

  assign ws_stb  = (r_state == ISSUE);
  assign ws_addr = r_ws_addr;
  assign ws_din  = r_ws_din;
  assign ws_dm   = r_ws_dm;
  assign ws_we   = r_ws_we;
  assign m0_ack  = (r_state == RESP) & ~r_grant;
  assign m1_ack  = (r_state == RESP) &  r_grant;
  assign m0_dout = r_m0_dout;
  assign m1_dout = r_m1_dout;

endmodule

// File: tb/tb_sram_line_arbiter.sv
// Directed bench for sram_line_arbiter: reads, guarded writes, round-robin, reset abort.
module tb_sram_line_arbiter;

  localparam logic [767:0] PAT_A = {16{48'hA5A5_A5A5_A5A5}};
  localparam logic [767:0] PAT_B = {16{48'h1234_5678_9ABC}};
  localparam logic [767:0] PAT_C = {16{48'h0F0F_F0F0_3C3C}};
  localparam logic [767:0] PAT_W = {16{48'hDEAD_BEEF_CAFE}};
  localparam logic [767:0] PAT_X = {16{48'h5555_AAAA_5555}};

  logic         clkCPU = 1'b0, rst = 1'b0;
  logic [31:0]  m0_addr = '0, m1_addr = '0;
  logic [767:0] m0_din = '0, m1_din = '0;
  logic [95:0]  m0_dm = '0, m1_dm = '0;
  logic         m0_stb = 1'b0, m0_we = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
  logic         m0_ack, m1_ack;
  logic [767:0] m0_dout, m1_dout;
  logic [31:0]  ws_addr;
  logic [767:0] ws_din;
  logic [95:0]  ws_dm;
  logic         ws_stb, ws_we;
  logic         ws_ack = 1'b0;
  logic [767:0] ws_dout = '0;
  logic         sram_stb_mon = 1'b0, sram_nak_mon = 1'b0;
`ifdef SRAM_LINE_ARB_TIMEOUT_EN
  logic         m0_err, m1_err;
`endif

  int checks = 0, failures = 0;

  sram_line_arbiter dut (
    .clkCPU(clkCPU), .rst(rst),
    .m0_addr(m0_addr), .m0_din(m0_din), .m0_dm(m0_dm), .m0_stb(m0_stb), .m0_we(m0_we),
    .m0_ack(m0_ack), .m0_dout(m0_dout),
    .m1_addr(m1_addr), .m1_din(m1_din), .m1_dm(m1_dm), .m1_stb(m1_stb), .m1_we(m1_we),
    .m1_ack(m1_ack), .m1_dout(m1_dout),
    .ws_addr(ws_addr), .ws_din(ws_din), .ws_dm(ws_dm), .ws_stb(ws_stb), .ws_we(ws_we),
    .ws_ack(ws_ack), .ws_dout(ws_dout),
    .sram_stb_mon(sram_stb_mon), .sram_nak_mon(sram_nak_mon)
`ifdef SRAM_LINE_ARB_TIMEOUT_EN
    , .m0_err(m0_err), .m1_err(m1_err)
`endif
  );

  always #5 clkCPU = ~clkCPU;

  task automatic tick();
    @(posedge clkCPU);
    #1;
  endtask

  task automatic chk(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ticks until ws_stb is seen or the limit expires; returns ticks taken.
  task automatic wait_stb(input int limit, output int n);
    n = 0;
    while (!ws_stb && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, nstb, nack;
    logic [31:0] exp_addr;

    // reset state
    tick(); tick();
    chk("rst_ws_stb", ws_stb, 0);
    chk("rst_ws_addr", ws_addr, 0);
    chk("rst_ws_we", ws_we, 0);
    chk("rst_acks", {m0_ack, m1_ack}, 0);
    chk("rst_m0_dout", m0_dout, 0);
    rst = 1'b1;
    tick();

    // m0 read, wrapper acks 20 cycles after stb
    m0_addr = 32'h0000_0100; m0_stb = 1'b1;
    tick();
    chk("rd_stb", ws_stb, 1);
    chk("rd_addr", ws_addr, 32'h100);
    chk("rd_we", ws_we, 0);
    tick();
    nstb = 0; nack = 0;
    repeat (19) begin
      if (ws_stb) nstb++;
      if (m0_ack || m1_ack) nack++;
      tick();
    end
    chk("rd_stb_single", nstb, 0);
    chk("rd_no_early_ack", nack, 0);
    ws_ack = 1'b1; ws_dout = PAT_A;
    chk("rd_ack_not_yet", m0_ack, 0);
    tick();
    ws_ack = 1'b0;
    chk("rd_m0_ack", m0_ack, 1);
    chk("rd_m1_ack", m1_ack, 0);
    chk("rd_m0_dout", m0_dout, PAT_A);
    m0_stb = 1'b0;
    tick();
    chk("rd_ack_pulse", m0_ack, 0);
    chk("rd_dout_hold", m0_dout, PAT_A);

    // m1 write, ack next cycle; m0 read queued behind guard with DRAIN held
    m1_addr = 32'h200; m1_din = PAT_W; m1_dm = '1; m1_we = 1'b1; m1_stb = 1'b1;
    tick();
    chk("wr_stb", ws_stb, 1);
    chk("wr_we", ws_we, 1);
    chk("wr_addr", ws_addr, 32'h200);
    chk("wr_dm", ws_dm, {96{1'b1}});
    chk("wr_din", ws_din, PAT_W);
    tick();
    ws_ack = 1'b1; ws_dout = PAT_X;
    chk("wr_ack_not_yet", m1_ack, 0);
    tick();
    ws_ack = 1'b0;
    chk("wr_m1_ack_T3", m1_ack, 1);
    chk("wr_m0_ack", m0_ack, 0);
    chk("wr_m1_dout_kept", m1_dout, 0);
    m1_stb = 1'b0; m1_we = 1'b0;
    sram_stb_mon = 1'b1;
    m0_addr = 32'h300; m0_stb = 1'b1;
    nstb = 0; nack = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      ws_ack = (i == 5);
      if (ws_stb) nstb++;
      if (m0_ack || m1_ack) nack++;
    end
    ws_ack = 1'b0;
    chk("guard_drain_no_stb", nstb, 0);
    chk("stray_ack_ignored", nack, 0);
    sram_stb_mon = 1'b0;
    tick();
    chk("drain_release_idle", ws_stb, 0);
    tick();
    chk("drain_release_issue", ws_stb, 1);
    chk("queued_addr", ws_addr, 32'h300);
    tick();
    ws_ack = 1'b1; ws_dout = PAT_B;
    tick();
    ws_ack = 1'b0;
    chk("queued_m0_ack", m0_ack, 1);
    chk("queued_m0_dout", m0_dout, PAT_B);
    m0_stb = 1'b0;
    tick();

    // exact write-to-next-issue spacing with monitors idle
    m1_addr = 32'h204; m1_we = 1'b1; m1_stb = 1'b1;
    tick(); tick();
    ws_ack = 1'b1;
    tick();
    ws_ack = 1'b0;
    chk("wr2_m1_ack", m1_ack, 1);
    m1_stb = 1'b0; m1_we = 1'b0;
    m0_addr = 32'h400; m0_stb = 1'b1;
    wait_stb(60, n);
    chk("guard_len", n, 22);
    chk("guard_next_addr", ws_addr, 32'h400);
    tick();
    chk("one_stb_per_txn", ws_stb, 0);
    ws_ack = 1'b1; ws_dout = PAT_C;
    tick();
    ws_ack = 1'b0;
    chk("wr2_m0_ack", m0_ack, 1);
    chk("wr2_m0_dout", m0_dout, PAT_C);
    m0_stb = 1'b0;
    tick();

    // round-robin from reset with both requesting
    rst = 1'b0; tick(); rst = 1'b1; tick();
    m0_addr = 32'hA00; m1_addr = 32'hB00; m0_stb = 1'b1; m1_stb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_addr = (k % 2 == 0) ? 32'hA00 : 32'hB00;
      wait_stb(10, n);
      chk($sformatf("rr_addr_%0d", k), ws_addr, exp_addr);
      tick();
      ws_ack = 1'b1; ws_dout = PAT_A ^ 768'(k);
      tick();
      ws_ack = 1'b0;
      chk($sformatf("rr_acks_%0d", k), {m0_ack, m1_ack}, (k % 2 == 0) ? 2'b10 : 2'b01);
      chk($sformatf("rr_dout_%0d", k), (k % 2 == 0) ? m0_dout : m1_dout, PAT_A ^ 768'(k));
      if (k % 2 == 0) m0_stb = 1'b0; else m1_stb = 1'b0;
      tick();
      if (k < 2) begin
        if (k % 2 == 0) m0_stb = 1'b1; else m1_stb = 1'b1;
      end
    end

    // reset while a read waits for its ack
    tick();
    m0_addr = 32'h500; m0_stb = 1'b1;
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    chk("rstmid_ws_stb", ws_stb, 0);
    chk("rstmid_acks", {m0_ack, m1_ack}, 0);
    chk("rstmid_ws_addr", ws_addr, 0);
    m0_stb = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    ws_ack = 1'b1; ws_dout = PAT_B;
    nack = 0; nstb = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      ws_ack = 1'b0;
      if (m0_ack || m1_ack) nack++;
      if (ws_stb) nstb++;
    end
    chk("late_ack_ignored", nack, 0);
    chk("late_ack_no_stb", nstb, 0);
    chk("rstmid_dout", m0_dout, 0);

`ifdef SRAM_LINE_ARB_TIMEOUT_EN
    // watchdog expiry with no wrapper ack
    m0_addr = 32'h600; m0_stb = 1'b1;
    tick(); tick();
    n = 0;
    while (!m0_ack && n < 1100) begin
      tick();
      n++;
    end
    chk("to_latency", n, 1023);
    chk("to_err", m0_err, 1);
    chk("to_m1_err", m1_err, 0);
    chk("to_dout_kept", m0_dout, 0);
    m0_stb = 1'b0;
    tick();
    chk("to_err_pulse", {m0_ack, m0_err}, 0);
    tick();
    chk("to_back_idle", ws_stb, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
